// File: rtl/lz_normalizer.sv
// Leading-zero/one normalizer: binary-search count of the leading run, plus the operand shifted
// left by that count. One search stage per cycle and a start/busy/done handshake.
module lz_normalizer #(
  parameter int W  = 32,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  din,
  input  logic          clo,
  output logic          busy,
  output logic          done,
  output logic [LW:0]   lzc,
  output logic          zero,
  output logic [W-1:0]  dout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [LW:0]   WL      = (LW+1)'(W);
  localparam logic [LW:0]   STEP1   = (LW+1)'(1);
  localparam logic [LW-1:0] S_ONE   = LW'(1);
  localparam logic [LW-1:0] S_LAST  = LW'(LW-1);

  state_t        state_q;
  logic [LW-1:0] s_q;
  logic [W-1:0]  w_q, w_d;
  logic [W-1:0]  d_q, d_d;
  logic [LW-1:0] c_q, c_d;
  logic          busy_q, done_q, zero_q;
  logic [LW:0]   lzc_q;
  logic [W-1:0]  dout_q;
  logic [LW:0]   step;

  // One search stage: step halves each cycle, W/2 down to 1.
  always_comb begin
    step = WL >> ({1'b0, s_q} + STEP1);
    w_d  = w_q;
    d_d  = d_q;
    c_d  = c_q;
    if ((w_q >> (WL - step)) == '0) begin
      w_d = w_q << step;
      d_d = d_q << step;
      c_d = c_q + step[LW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lzc_q   <= '0;
      zero_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            // w tracks the search; d is the untouched operand shifted in lockstep.
            w_q     <= clo ? ~din : din;
            d_q     <= din;
            c_q     <= '0;
            s_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          w_q <= w_d;
          d_q <= d_d;
          c_q <= c_d;
          if (s_q == S_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!w_d[W-1]) begin
              lzc_q  <= WL;
              zero_q <= 1'b1;
              dout_q <= '0;
            end else begin
              lzc_q  <= {1'b0, c_d};
              zero_q <= 1'b0;
              dout_q <= d_d;
            end
          end else begin
            s_q <= s_q + S_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lzc  = lzc_q;
  assign zero = zero_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_lz_normalizer.sv
// Bench for lz_normalizer: directed scenarios plus randomized operands against a bit-scan model.
module tb_lz_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] din = '0;
  logic        clo = 1'b0;
  logic        busy, done, zero;
  logic [5:0]  lzc;
  logic [31:0] dout;

  int errors = 0;
  int checks = 0;

  lz_normalizer #(.W(32), .LW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .clo(clo),
    .busy(busy), .done(done), .lzc(lzc), .zero(zero), .dout(dout)
  );

  always #5 clk = ~clk;

  // Reference: scan from the MSB counting bits equal to the mode bit.
  function automatic void model(input logic [31:0] a, input logic m,
                                output int n, output logic [31:0] o);
    n = 0;
    while (n < 32 && a[31-n] == m) n++;
    o = (n == 32) ? 32'h0 : (a << n);
  endfunction

  // Drives one start and waits (bounded) for done; returns observations only.
  // Returns at the negedge in which done is seen; lat counts negedges after the accept edge.
  task automatic run_op(input logic [31:0] a, input logic m, input bit align,
                        output int lat, output int nbusy);
    if (align) @(negedge clk);
    start = 1'b1; din = a; clo = m;
    @(posedge clk);
    #1 start = 1'b0; din = 32'h0; clo = 1'b0;
    lat = 0; nbusy = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) return;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    logic [31:0] d0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lzc !== 6'd0 || zero !== 1'b0 || dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b lzc=%0d zero=%b dout=%h, want all 0",
               busy, done, lzc, zero, dout);
    end
    d0 = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || lzc !== 6'd0 || dout !== d0) begin
        checks++; errors++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b lzc=%0d dout=%h, want 0", i, busy, done, lzc, dout);
        break;
      end
    end
    checks++;
  endtask

  task automatic test_basic();
    int lat, nb;
    run_op(32'h0001_0000, 1'b0, 1'b1, lat, nb);
    checks++;
    if (lat !== 6 || nb !== 5) begin
      errors++;
      $display("FAIL basic_timing: latency=%0d busy_cycles=%0d, want 6 and 5", lat, nb);
    end
    checks++;
    if (lzc !== 6'd15 || zero !== 1'b0 || dout !== 32'h8000_0000) begin
      errors++;
      $display("FAIL basic_result: lzc=%0d zero=%b dout=%h, want 15 0 80000000", lzc, zero, dout);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || lzc !== 6'd15 || dout !== 32'h8000_0000) begin
        errors++;
        $display("FAIL basic_hold cycle %0d: done=%b busy=%b lzc=%0d dout=%h, want 0 0 15 80000000",
                 i, done, busy, lzc, dout);
      end
    end
  endtask

  task automatic test_extremes();
    logic [31:0] vec [3] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    int          el   [3] = '{0, 31, 32};
    logic [31:0] ed   [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0};
    logic        ez   [3] = '{1'b0, 1'b0, 1'b1};
    int lat, nb;
    for (int i = 0; i < 3; i++) begin
      run_op(vec[i], 1'b0, 1'b1, lat, nb);
      checks++;
      if (lat !== 6 || lzc !== 6'(el[i]) || zero !== ez[i] || dout !== ed[i]) begin
        errors++;
        $display("FAIL extreme din=%h: lat=%0d lzc=%0d zero=%b dout=%h, want 6 %0d %b %h",
                 vec[i], lat, lzc, zero, dout, el[i], ez[i], ed[i]);
      end
    end
  endtask

  task automatic test_clo();
    int lat, nb;
    run_op(32'hFFF0_1234, 1'b1, 1'b1, lat, nb);
    checks++;
    if (lat !== 6 || lzc !== 6'd12 || zero !== 1'b0 || dout !== 32'h0123_4000) begin
      errors++;
      $display("FAIL clo_partial: lat=%0d lzc=%0d zero=%b dout=%h, want 6 12 0 01234000", lat, lzc, zero, dout);
    end
    run_op(32'hFFFF_FFFF, 1'b1, 1'b1, lat, nb);
    checks++;
    if (lat !== 6 || lzc !== 6'd32 || zero !== 1'b1 || dout !== 32'h0) begin
      errors++;
      $display("FAIL clo_allones: lat=%0d lzc=%0d zero=%b dout=%h, want 6 32 1 0", lat, lzc, zero, dout);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    start = 1'b1; din = 32'h0000_0F00; clo = 1'b0;
    @(posedge clk);
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (done) begin start = 1'b0; din = 32'h0; break; end
      start = 1'b1; din = 32'h0000_0001; clo = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (lat !== 6 || lzc !== 6'd20 || zero !== 1'b0 || dout !== 32'hF000_0000) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d lzc=%0d zero=%b dout=%h, want 6 20 0 f0000000", lat, lzc, zero, dout);
    end
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || lzc !== 6'd20) begin
        errors++;
        $display("FAIL busy_no_queue: busy=%b done=%b lzc=%0d, want 0 0 20", busy, done, lzc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    run_op(32'h0000_0F00, 1'b0, 1'b1, lat, nb);
    checks++;
    if (lat !== 6 || lzc !== 6'd20) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d lzc=%0d, want 6 20", lat, lzc);
    end
    // Launch B from inside A's done cycle.
    run_op(32'h0000_0001, 1'b0, 1'b0, lat, nb);
    checks++;
    if (lat !== 6 || nb !== 5 || lzc !== 6'd31 || dout !== 32'h8000_0000) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d busy=%0d lzc=%0d dout=%h, want 6 5 31 80000000", lat, nb, lzc, dout);
    end
  endtask

  task automatic test_reset_midop();
    int lat, nb;
    bit seen;
    @(negedge clk);
    start = 1'b1; din = 32'h0000_0100; clo = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lzc !== 6'd0 || zero !== 1'b0 || dout !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset: busy=%b done=%b lzc=%0d zero=%b dout=%h, want all 0", busy, done, lzc, zero, dout);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midop_discard: activity after reset seen=%b, want 0", seen);
    end
    run_op(32'h0000_0100, 1'b0, 1'b1, lat, nb);
    checks++;
    if (lat !== 6 || lzc !== 6'd23 || zero !== 1'b0 || dout !== 32'h8000_0000) begin
      errors++;
      $display("FAIL midop_after: lat=%0d lzc=%0d zero=%b dout=%h, want 6 23 0 80000000", lat, lzc, zero, dout);
    end
  endtask

  task automatic test_random();
    int lat, nb, en;
    logic [31:0] a, eo;
    logic m;
    for (int i = 0; i < 60; i++) begin
      a = $urandom() >> $urandom_range(0, 32);
      m = 1'($urandom_range(0, 1));
      if (m) a = ~a;
      model(a, m, en, eo);
      run_op(a, m, ($urandom_range(0, 1) == 1), lat, nb);
      checks++;
      if (lat !== 6 || lzc !== 6'(en) || zero !== (en == 32) || dout !== eo) begin
        errors++;
        $display("FAIL random din=%h clo=%b: lat=%0d lzc=%0d zero=%b dout=%h, want 6 %0d %b %h",
                 a, m, lat, lzc, zero, dout, en, (en == 32), eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_clo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lz_normalizer.md
Name: lz_normalizer

Overview:
- Multi-cycle normalizer: the inverse operation of the ALU barrel shifter. The shifter takes data and a shift amount and produces shifted data. This block takes data and produces the shift amount plus the normalized data.
- Computes the leading-zero count (or leading-one count) of a word, and the word left-shifted by that count.
- Binary-search method: one stage per cycle, log2(W) stages.
- Sits beside the ALU. Used for clz/clo-style operations and for software-float normalization. A start/busy/done handshake lets the control unit stall on it.

Parameters:
- W, 32, data width; power of two, at least 4.
- LW, 5, log2(W); number of search stages; must equal log2(W).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled on the rising edge; accepted only when busy=0.
- din  in  W  operand; captured on an accepted start.
- clo  in  1  mode, captured with din: 0 = count leading zeros, 1 = count leading ones.
- busy  out  1  high while a search is in progress (RUN state).
- done  out  1  one-cycle pulse when results become valid.
- lzc  out  LW+1  count, 0..W.
- zero  out  1  high when no terminating bit was found (lzc = W).
- dout  out  W  din shifted left by lzc, zero-filled.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, lzc=0, zero=0, dout=0; internal stage counter=0. Applies from any state, including mid-search; an in-flight operation is discarded and no done is produced.
- States:
  - IDLE: waiting for start.
  - RUN: stage counter s = 0..LW-1.
  - DONE: one cycle, done=1.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --(s = LW-1)--> DONE.
  - DONE --start--> RUN (back-to-back accept); DONE --no start--> IDLE.
- Accept (edge E0, state IDLE or DONE, start=1):
  - Working register w = din when clo=0, ~din when clo=1.
  - Shadow data register d = din; count c = 0; s = 0; state=RUN.
- Stage k (edges E1..E(LW), k = 0..LW-1), with step = W >> (k+1):
  - If the top step bits of w are all zero: w <<= step, d <<= step (zero fill), c += step.
  - Otherwise hold.
- At edge E(LW):
  - If w[W-1] = 0 after the last stage (all-zero case): lzc = W, zero = 1, dout = 0.
  - Otherwise: lzc = c, zero = 0, dout = d.
  - done = 1 for the following cycle only.
- Latency: done is high in the cycle after edge E(LW), i.e. LW+1 clock edges after the accepting edge (6 for W=32).
- Output hold: lzc, zero and dout update only at result time. They stay stable from then until the next result or reset, including while a new search runs.
- busy = 1 exactly while state = RUN; busy = 0 in IDLE and DONE.
- start while busy=1: ignored entirely; no queuing, and operands are not re-captured.
- start during the DONE cycle: accepted; the done pulse still occurs that cycle.
- Mode clo=1 on all-ones din: lzc = W, zero = 1, dout = 0.
- Width rule: c fits in LW bits (maximum W-1 from the stages); lzc is LW+1 bits so that W can be represented.
- din and clo are don't-care except on the accepting edge.

Test Plan:
- Reset: hold rst for 2 cycles, then release -> busy=0, done=0, lzc=0, zero=0, dout=0. With no start, nothing changes for 20 cycles.
- Basic clz: din=0x00010000, clo=0, start for 1 cycle -> busy for 5 cycles; done pulse 6 edges after accept with lzc=15, zero=0, dout=0x80000000. Outputs held afterwards.
- Extremes:
  - din=0x80000000 -> lzc=0, dout=0x80000000.
  - din=0x00000001 -> lzc=31, dout=0x80000000.
  - din=0x00000000 -> lzc=32, zero=1, dout=0x00000000.
- clo mode:
  - din=0xFFF01234, clo=1 -> lzc=12, zero=0, dout=0x01234000.
  - din=0xFFFFFFFF, clo=1 -> lzc=32, zero=1, dout=0.
- Handshake:
  - Start A=0x00000F00, then assert start with B=0x1 on every cycle while busy -> result is A only: lzc=20, dout=0xF0000000.
  - Start B during A's done cycle -> accepted back-to-back; second done gives lzc=31.
- Reset mid-op: start din=0x00000100, assert rst on the 3rd RUN cycle -> no done pulse; all outputs 0; state IDLE. A subsequent start with 0x00000100 yields lzc=23, dout=0x80000000.
